// File: rtl/alu_pkg.sv
// Shared encodings for the parameterised ALU: operation codes, compare conditions and FSM states.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_PAR = 4'd4,
        OP_CMP = 4'd5,
        OP_XOR = 4'd6
    } op_e;

    localparam logic [2:0] COND_EQ = 3'd0;
    localparam logic [2:0] COND_LE = 3'd1;
    localparam logic [2:0] COND_GE = 3'd2;
    localparam logic [2:0] COND_NE = 3'd3;
    localparam logic [2:0] COND_LT = 3'd4;
    localparam logic [2:0] COND_GT = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PAR  = 2'd1,
        HOLD = 2'd2
    } state_e;

    function automatic logic nib_parity(input logic [3:0] nib);
        return ^nib;
    endfunction

endpackage

// File: rtl/alu_comb.sv
// Single-cycle combinational datapath: arithmetic, logic, compare and flags.
module alu_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       cond,
    output logic [WIDTH-1:0] result,
    output logic             compres,
    output logic             carry,
    output logic             zero,
    output logic             illegal
);

    logic [WIDTH:0] sum_s;

    // Operation decode; parity yields zero here because it is iterated in the top.
    always_comb begin
        sum_s   = '0;
        result  = '0;
        compres = 1'b0;
        carry   = 1'b0;
        illegal = 1'b0;
        case (op)
            OP_ADD: begin
                sum_s  = {1'b0, a} + {1'b0, b};
                result = sum_s[WIDTH-1:0];
                carry  = sum_s[WIDTH];
            end
            OP_SUB: begin
                sum_s  = {1'b0, a} - {1'b0, b};
                result = sum_s[WIDTH-1:0];
                carry  = sum_s[WIDTH];
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_PAR: result = '0;
            OP_CMP: begin
                case (cond)
                    COND_EQ: compres = (a == b);
                    COND_LE: compres = (a <= b);
                    COND_GE: compres = (a >= b);
                    COND_NE: compres = (a != b);
                    COND_LT: compres = (a < b);
                    COND_GT: compres = (a > b);
                    default: compres = 1'b0;
                endcase
                result = {{(WIDTH-1){1'b0}}, compres};
            end
            default: illegal = 1'b1;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/param_alu.sv
// ALU with valid/ready handshake: one-cycle ops plus a nibble-serial parity, results held until taken.
module param_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       cond,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             compres,
    output logic             carry,
    output logic             zero,
    output logic             illegal
);

    localparam int NIBS = WIDTH / 4;
    localparam int CW   = $clog2(NIBS);

    state_e           state_r;
    logic [WIDTH-1:0] a_r;
    logic             par_r;
    logic [CW-1:0]    cnt_r;
    logic             out_valid_r;
    logic [WIDTH-1:0] result_r;
    logic             compres_r;
    logic             carry_r;
    logic             zero_r;
    logic             illegal_r;

    logic [WIDTH-1:0] result_s;
    logic             compres_s;
    logic             carry_s;
    logic             zero_s;
    logic             illegal_s;
    logic             par_next_s;

    alu_comb #(.WIDTH(WIDTH)) u_comb (
        .op      (op),
        .a       (a),
        .b       (b),
        .cond    (cond),
        .result  (result_s),
        .compres (compres_s),
        .carry   (carry_s),
        .zero    (zero_s),
        .illegal (illegal_s)
    );

    assign par_next_s = par_r ^ nib_parity(a_r[3:0]);

    // FSM, parity iteration and output registers. The lowest nibble is folded on the
    // accept edge so the final result lands exactly WIDTH/4 cycles after accept.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            a_r         <= '0;
            par_r       <= 1'b0;
            cnt_r       <= '0;
            out_valid_r <= 1'b0;
            result_r    <= '0;
            compres_r   <= 1'b0;
            carry_r     <= 1'b0;
            zero_r      <= 1'b0;
            illegal_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        if (op == OP_PAR) begin
                            state_r <= PAR;
                            a_r     <= a >> 3'd4;
                            par_r   <= nib_parity(a[3:0]);
                            cnt_r   <= '0;
                        end else begin
                            state_r     <= HOLD;
                            result_r    <= result_s;
                            compres_r   <= compres_s;
                            carry_r     <= carry_s;
                            zero_r      <= zero_s;
                            illegal_r   <= illegal_s;
                            out_valid_r <= 1'b1;
                        end
                    end
                end
                PAR: begin
                    par_r <= par_next_s;
                    a_r   <= a_r >> 3'd4;
                    if (cnt_r == CW'(NIBS - 2)) begin
                        state_r     <= HOLD;
                        cnt_r       <= '0;
                        result_r    <= {{(WIDTH-1){1'b0}}, par_next_s};
                        compres_r   <= 1'b0;
                        carry_r     <= 1'b0;
                        zero_r      <= ~par_next_s;
                        illegal_r   <= 1'b0;
                        out_valid_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_r     <= IDLE;
                        out_valid_r <= 1'b0;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_r == IDLE);
    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign compres   = compres_r;
    assign carry     = carry_r;
    assign zero      = zero_r;
    assign illegal   = illegal_r;

endmodule

// File: tb/tb_param_alu.sv
// Directed scoreboard bench for param_alu at WIDTH=16.
module tb_param_alu;

    localparam int W = 16;

    logic         clock = 1'b0;
    logic         reset_n = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [3:0]   op = 4'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [2:0]   cond = 3'd0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic         compres, carry, zero, illegal;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [W-1:0] result;
        logic         compres;
        logic         carry;
        logic         zero;
        logic         illegal;
        int           lat;
    } exp_t;

    exp_t sb[$];

    always #5 clock = ~clock;

    param_alu #(.WIDTH(W)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .cond      (cond),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .compres   (compres),
        .carry     (carry),
        .zero      (zero),
        .illegal   (illegal)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] x,
                                   input logic [W-1:0] y, input logic [2:0] c);
        exp_t e;
        int unsigned xi, yi;
        xi = x;
        yi = y;
        e.result = '0; e.compres = 1'b0; e.carry = 1'b0; e.illegal = 1'b0; e.lat = 0;
        if (o == 4'd0) begin
            e.result = W'(xi + yi);
            e.carry  = (xi + yi) >= 32'd65536;
        end else if (o == 4'd1) begin
            e.result = W'(xi - yi);
            e.carry  = xi < yi;
        end else if (o == 4'd2) e.result = x & y;
        else if (o == 4'd3) e.result = x | y;
        else if (o == 4'd6) e.result = x ^ y;
        else if (o == 4'd4) begin
            e.result = {{(W-1){1'b0}}, ^x};
            e.lat    = W / 4 - 1;
        end else if (o == 4'd5) begin
            if (c == 3'd0)      e.compres = (xi == yi);
            else if (c == 3'd1) e.compres = (xi <= yi);
            else if (c == 3'd2) e.compres = (xi >= yi);
            else if (c == 3'd3) e.compres = (xi != yi);
            else if (c == 3'd4) e.compres = (xi < yi);
            else if (c == 3'd5) e.compres = (xi > yi);
            else                e.compres = 1'b0;
            e.result = {{(W-1){1'b0}}, e.compres};
        end else e.illegal = 1'b1;
        e.zero = (e.result == '0);
        return e;
    endfunction

    // Presents one request, records its expected outcome, and leaves right after the accept edge.
    task automatic send(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [2:0] c, input bit push);
        int n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clock); #1; n++;
        end
        if (!in_ready) check("send_ready_timeout", 32'd0, 32'd1);
        if (push) sb.push_back(model(o, x, y, c));
        op = o; a = x; b = y; cond = c; in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
    endtask

    // Waits for a result, compares it against the scoreboard over `hold` stalled cycles, then handshakes.
    task automatic receive(input int hold, input bit poke);
        exp_t e;
        int n = 0;
        while (!out_valid && n < 40) begin
            check("busy_in_ready", 32'(in_ready), 32'd0);
            @(posedge clock); #1; n++;
        end
        check("out_valid_seen", 32'(out_valid), 32'd1);
        if (sb.size() == 0) begin
            check("sb_nonempty", 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        check("latency", 32'(n), 32'(e.lat));
        for (int h = 0; h <= hold; h++) begin
            check("result",   32'(result),   32'(e.result));
            check("compres",  32'(compres),  32'(e.compres));
            check("carry",    32'(carry),    32'(e.carry));
            check("zero",     32'(zero),     32'(e.zero));
            check("illegal",  32'(illegal),  32'(e.illegal));
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_valid", 32'(out_valid), 32'd1);
            if (poke) begin
                in_valid = 1'b1; op = 4'd0; a = 16'h1234; b = 16'h1111;
            end
            if (h < hold) begin
                @(posedge clock); #1;
            end
        end
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("hs_valid_drop", 32'(out_valid), 32'd0);
        check("hs_in_ready", 32'(in_ready), 32'd1);
        @(posedge clock); #1;
        check("no_exit_accept", 32'(in_ready), 32'd1);
    endtask

    initial begin
        #2 reset_n = 1'b0;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_flags", {28'd0, compres, carry, zero, illegal}, 32'd0);
        @(posedge clock); @(posedge clock); #1;
        reset_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clock); #1;
        check("idle_out_ready", 32'(out_valid), 32'd0);
        out_ready = 1'b0;

        send(4'd0, 16'hFFFF, 16'h0001, 3'd0, 1'b1); receive(0, 1'b0);
        send(4'd1, 16'h0003, 16'h0005, 3'd0, 1'b1); receive(0, 1'b0);
        send(4'd0, 16'h1234, 16'h4321, 3'd0, 1'b1); receive(0, 1'b0);
        send(4'd1, 16'h8000, 16'h0001, 3'd0, 1'b1); receive(0, 1'b0);
        send(4'd2, 16'hF0F0, 16'h3CC3, 3'd0, 1'b1); receive(0, 1'b0);
        send(4'd3, 16'hF000, 16'h000F, 3'd0, 1'b1); receive(0, 1'b0);
        send(4'd6, 16'hAAAA, 16'hAAAA, 3'd0, 1'b1); receive(0, 1'b0);
        send(4'd4, 16'h0007, 16'h0000, 3'd0, 1'b1); receive(0, 1'b1);
        send(4'd4, 16'h6996, 16'h0000, 3'd0, 1'b1); receive(0, 1'b0);
        send(4'd4, 16'h8000, 16'h0000, 3'd0, 1'b1); receive(1, 1'b0);
        send(4'd5, 16'h0002, 16'h0005, 3'd4, 1'b1); receive(0, 1'b0);
        send(4'd5, 16'h0002, 16'h0005, 3'd5, 1'b1); receive(0, 1'b0);
        send(4'd5, 16'h0002, 16'h0005, 3'd7, 1'b1); receive(0, 1'b0);
        send(4'd5, 16'h7777, 16'h7777, 3'd0, 1'b1); receive(0, 1'b0);
        send(4'd5, 16'h9000, 16'h0900, 3'd2, 1'b1); receive(0, 1'b0);
        send(4'd9, 16'h1234, 16'h5678, 3'd0, 1'b1); receive(3, 1'b1);

        // Reset in the second cycle of a parity operation discards it.
        send(4'd4, 16'h0001, 16'h0000, 3'd0, 1'b0);
        @(posedge clock); #1;
        reset_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clock); #1;
        reset_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clock); #1;
            check("post_rst_no_valid", 32'(out_valid), 32'd0);
        end
        out_ready = 1'b0;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        check("sb_drained", 32'(sb.size()), 32'd0);

        send(4'd0, 16'h0010, 16'h0020, 3'd0, 1'b1); receive(0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/param_alu.md
PARAM_ALU -- requirements
Module: param_alu

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width; SHALL be a multiple of 4 and at least 8.
REQ-002 Port clock  in  1  sole clock; all state updates on its rising edge.
REQ-003 Port reset_n  in  1  reset, asynchronous and active-low.
REQ-004 Port in_valid  in  1  request present on op/a/b/cond.
REQ-005 Port in_ready  out  1  block can accept a request.
REQ-006 Port op  in  4  operation: 0 add, 1 sub, 2 and, 3 or, 4 parity, 5 compare, 6 xor; 7-15 illegal.
REQ-007 Port a  in  WIDTH  first operand.
REQ-008 Port b  in  WIDTH  second operand.
REQ-009 Port cond  in  3  compare condition: 0 eq, 1 le, 2 ge, 3 ne, 4 lt, 5 gt; 6-7 reserved.
REQ-010 Port out_valid  out  1  result/flags valid.
REQ-011 Port out_ready  in  1  consumer takes the result.
REQ-012 Port result  out  WIDTH  registered result.
REQ-013 Port compres  out  1  registered compare outcome.
REQ-014 Port carry  out  1  carry-out of add; borrow of sub (1 when a < b unsigned).
REQ-015 Port zero  out  1  1 when result == 0.
REQ-016 Port illegal  out  1  1 when the completed op was 7-15.

Function
REQ-017 FSM states IDLE, PAR, HOLD; in_ready SHALL be 1 exactly when state is IDLE.
REQ-018 Accept = in_valid & in_ready; op, a, b, cond latched on accept.
REQ-019 Ops 0-3, 5, 6 and 7-15: IDLE -> HOLD on accept; out_valid asserted the cycle after accept (latency 1).
REQ-020 Add/sub modulo 2^WIDTH, unsigned; carry taken from bit WIDTH of the WIDTH+1-bit sum/difference.
REQ-021 Parity: IDLE -> PAR; 4 bits of latched a folded per cycle, LSB nibble first, for WIDTH/4 cycles; then HOLD.
REQ-022 Parity result = XOR of all bits of a in bit 0, upper bits 0; out_valid at accept + WIDTH/4 cycles.
REQ-023 Compare: unsigned a vs b per cond; result = {0..., compres}; reserved cond gives compres 0.
REQ-024 For non-compare ops compres SHALL be 0; for ops other than add/sub carry SHALL be 0.
REQ-025 Illegal op: result 0, zero 1, illegal 1, latency 1.
REQ-026 HOLD: result, flags and out_valid held stable until out_ready; out_valid & out_ready -> IDLE next cycle.
REQ-027 No accept in the HOLD exit cycle; in_ready rises the cycle after the handshake.
REQ-028 in_valid or operand changes while not IDLE SHALL be ignored.
REQ-029 out_ready while out_valid=0 SHALL have no effect.

Reset
REQ-030 reset_n low SHALL immediately force state IDLE and out_valid, result, compres, carry, zero, illegal to 0, and the parity accumulator and nibble counter to 0.
REQ-031 in_ready SHALL read 1 during and after reset.
REQ-032 Reset asserted in PAR or HOLD SHALL discard the operation; no result is produced for it.

Structure
REQ-033 Shared package alu_pkg SHALL hold op encodings, cond encodings and the FSM state enum.
REQ-034 Combinational datapath for single-cycle ops (add/sub/and/or/xor/compare/flags) SHALL be sub-module alu_comb; FSM, parity iteration and output registers stay in param_alu.

Verification (WIDTH=16)
REQ-035 add a=0xFFFF b=0x0001 -> out_valid 1 cycle after accept, result 0x0000, carry 1, zero 1.
REQ-036 sub a=0x0003 b=0x0005 -> result 0xFFFE, carry 1, zero 0, compres 0.
REQ-037 parity a=0x0007 -> in_ready 0 for 4 cycles, out_valid at accept+4, result 0x0001; a=0x6996 -> result 0x0000, zero 1.
REQ-038 compare a=2 b=5 cond=4 -> compres 1, result 0x0001; cond=5 -> compres 0; cond=7 -> compres 0.
REQ-039 op=9 -> result 0x0000, illegal 1; out_ready held 0 for 3 cycles -> outputs stable, in_ready 0; handshake -> in_ready 1 next cycle.
REQ-040 reset_n low during cycle 2 of a parity op -> out_valid 0 at once, no result after release, in_ready 1.
